// File: rtl/layer5_chan_acc.sv
// layer5_chan_acc: eight-lane channel accumulator feeding the BRAM32k writer.
// Sums partials over input-channel passes, then drains int8-packed words.
module layer5_chan_acc #(
  parameter int DEPTH  = 64,
  parameter int LANE_W = 22,
  parameter int SHIFT  = 9,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        num_pass,
  input  logic [AW-1:0]     last_addr,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [LANE_W-1:0] wdata1,
  input  logic [LANE_W-1:0] wdata2,
  input  logic [LANE_W-1:0] wdata3,
  input  logic [LANE_W-1:0] wdata4,
  input  logic [LANE_W-1:0] wdata5,
  input  logic [LANE_W-1:0] wdata6,
  input  logic [LANE_W-1:0] wdata7,
  input  logic [LANE_W-1:0] wdata8,
  output logic [63:0]       dout,
  output logic              dout_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [7:0]    pass_q, pass_d;
  logic [7:0]    np_q, np_d;
  logic [AW-1:0] la_q, la_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          issued_q, issued_d;
  logic          s1_v_q, s1_v_d;
  logic          s1_last_q, s1_last_d;
  logic [63:0]   dout_q, dout_d;
  logic          dv_q, dv_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;

  logic signed [LANE_W-1:0] s1_q [8];
  logic signed [LANE_W-1:0] s1_d [8];
  logic signed [LANE_W-1:0] mem_q [DEPTH][8];

  logic signed [LANE_W-1:0] wd [8];
  logic signed [LANE_W-1:0] wval [8];
  logic signed [LANE_W-1:0] shr [8];
  logic [LANE_W:0]          sum [8];
  logic [7:0]               sat;
  logic [63:0]              pk;
  logic                     mem_we;
  logic                     out_load;
  logic                     s1_free;

  assign wd[0] = wdata1;
  assign wd[1] = wdata2;
  assign wd[2] = wdata3;
  assign wd[3] = wdata4;
  assign wd[4] = wdata5;
  assign wd[5] = wdata6;
  assign wd[6] = wdata7;
  assign wd[7] = wdata8;

  // First pass overwrites, so the buffer never needs a clearing sweep.
  always_comb begin
    sat = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = {mem_q[waddr][i][LANE_W-1], mem_q[waddr][i]}
             + {wd[i][LANE_W-1], wd[i]};
      sat[i] = sum[i][LANE_W] ^ sum[i][LANE_W-1];
      if (pass_q == 8'd0) begin
        wval[i] = wd[i];
      end else if (sat[i]) begin
        wval[i] = {sum[i][LANE_W], {(LANE_W-1){~sum[i][LANE_W]}}};
      end else begin
        wval[i] = sum[i][LANE_W-1:0];
      end
    end
  end

  always_comb begin
    pk = '0;
    for (int i = 0; i < 8; i++) begin
      shr[i] = s1_q[i] >>> SHIFT;
      if (!shr[i][LANE_W-1] && (|shr[i][LANE_W-2:7])) begin
        pk[63-8*i -: 8] = 8'h7f;
      end else if (shr[i][LANE_W-1] && !(&shr[i][LANE_W-2:7])) begin
        pk[63-8*i -: 8] = 8'h80;
      end else begin
        pk[63-8*i -: 8] = shr[i][7:0];
      end
    end
  end

  assign out_load = !dv_q || rd_ready;
  assign s1_free  = !s1_v_q || out_load;

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    np_d      = np_q;
    la_d      = la_q;
    rd_ptr_d  = rd_ptr_q;
    issued_d  = issued_q;
    s1_v_d    = s1_v_q;
    s1_last_d = s1_last_q;
    dout_d    = dout_q;
    dv_d      = dv_q;
    last_d    = last_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    mem_we    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s1_d[i] = s1_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          np_d    = (num_pass == 8'd0) ? 8'd1 : num_pass;
          la_d    = last_addr;
          pass_d  = '0;
          ovf_d   = 1'b0;
          state_d = ACC;
        end
      end
      ACC: begin
        if (we && (waddr <= la_q)) begin
          mem_we = 1'b1;
          if ((pass_q != 8'd0) && (|sat)) begin
            ovf_d = 1'b1;
          end
          if (waddr == la_q) begin
            pass_d = pass_q + 8'd1;
            if ((pass_q + 8'd1) == np_q) begin
              pass_d   = '0;
              rd_ptr_d = '0;
              issued_d = 1'b0;
              s1_v_d   = 1'b0;
              dv_d     = 1'b0;
              state_d  = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (s1_free) begin
          s1_v_d = !issued_q;
          if (!issued_q) begin
            for (int i = 0; i < 8; i++) begin
              s1_d[i] = mem_q[rd_ptr_q][i];
            end
            s1_last_d = (rd_ptr_q == la_q);
            issued_d  = (rd_ptr_q == la_q);
            rd_ptr_d  = rd_ptr_q + 1'b1;
          end
        end
        if (out_load) begin
          dv_d = s1_v_q;
          if (s1_v_q) begin
            dout_d = pk;
            last_d = s1_last_q;
          end
        end
        if (dv_q && rd_ready && last_q) begin
          dv_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      state_d  = IDLE;
      pass_d   = '0;
      rd_ptr_d = '0;
      s1_v_d   = 1'b0;
      dv_d     = 1'b0;
      done_d   = 1'b0;
      ovf_d    = 1'b0;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pass_q    <= '0;
      np_q      <= 8'd1;
      la_q      <= '0;
      rd_ptr_q  <= '0;
      issued_q  <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      pass_q    <= pass_d;
      np_q      <= np_d;
      la_q      <= la_d;
      rd_ptr_q  <= rd_ptr_d;
      issued_q  <= issued_d;
      s1_v_q    <= s1_v_d;
      s1_last_q <= s1_last_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      last_q    <= last_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < 8; i++) begin
        s1_q[i] <= s1_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 8; i++) begin
        mem_q[waddr][i] <= wval[i];
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_layer5_chan_acc.sv
// tb_layer5_chan_acc: directed bench with a pass-level accumulator model.
// A negedge monitor scoreboards every handshaken word and the done pulse.
module tb_layer5_chan_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_pass = '0;
  logic [5:0]  last_addr = '0;
  logic        we = 1'b0;
  logic [5:0]  waddr = '0;
  logic [21:0] wdata1 = '0, wdata2 = '0, wdata3 = '0, wdata4 = '0;
  logic [21:0] wdata5 = '0, wdata6 = '0, wdata7 = '0, wdata8 = '0;
  logic        rd_ready = 1'b1;
  logic [63:0] dout;
  logic        dout_valid, done, busy, ovf;

  layer5_chan_acc dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .num_pass(num_pass), .last_addr(last_addr),
    .we(we), .waddr(waddr),
    .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3), .wdata4(wdata4),
    .wdata5(wdata5), .wdata6(wdata6), .wdata7(wdata7), .wdata8(wdata8),
    .dout(dout), .dout_valid(dout_valid), .rd_ready(rd_ready),
    .done(done), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: accumulator contents, pass bookkeeping, expected word stream.
  int          macc [64][8];
  int          wv [8];
  int          m_pass, m_np, m_la;
  bit          m_acc = 1'b0;
  bit          m_ovf = 1'b0;
  logic [63:0] exp_q [$];
  logic [63:0] got_q [$];
  int          done_cnt = 0;
  bit          exp_done = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_dout = '0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int a);
    logic [63:0] w;
    int q;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      q = macc[a][i] >>> 9;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      w[63-8*i -: 8] = q[7:0];
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int np, input int la);
    start = 1'b1;
    num_pass = np[7:0];
    last_addr = la[5:0];
    m_acc = 1'b1;
    m_np = (np == 0) ? 1 : np;
    m_la = la;
    m_pass = 0;
    m_ovf = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic do_write(input int a);
    int s;
    we = 1'b1;
    waddr = a[5:0];
    wdata1 = wv[0][21:0];
    wdata2 = wv[1][21:0];
    wdata3 = wv[2][21:0];
    wdata4 = wv[3][21:0];
    wdata5 = wv[4][21:0];
    wdata6 = wv[5][21:0];
    wdata7 = wv[6][21:0];
    wdata8 = wv[7][21:0];
    if (m_acc && a <= m_la) begin
      for (int i = 0; i < 8; i++) begin
        if (m_pass == 0) begin
          macc[a][i] = wv[i];
        end else begin
          s = macc[a][i] + wv[i];
          if (s > 2097151) begin
            s = 2097151;
            m_ovf = 1'b1;
          end else if (s < -2097152) begin
            s = -2097152;
            m_ovf = 1'b1;
          end
          macc[a][i] = s;
        end
      end
      if (a == m_la) begin
        m_pass++;
        if (m_pass == m_np) begin
          m_acc = 1'b0;
          for (int k = 0; k <= m_la; k++) exp_q.push_back(word_of(k));
        end
      end
    end
    step();
    we = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      rd_ready = pat[n%4];
      step();
      n++;
    end
    rd_ready = 1'b1;
    chk("drain_timeout", busy, 0);
    step();
  endtask

  // Compare process: inputs are stable at negedge, so this sees exactly
  // what the following rising edge will sample.
  always @(negedge clk) begin
    logic [63:0] e;
    bit nd;
    if (rst) begin
      nd = 1'b0;
      chk("done", done, exp_done);
      if (done) done_cnt++;
      if (clr) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", dout_valid, 1);
          chk("hold_dout", dout, prev_dout);
        end
        if (dout_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %h, want none", dout);
          end else begin
            e = exp_q.pop_front();
            chk("word", dout, e);
            if (exp_q.size() == 0) nd = 1'b1;
          end
          got_q.push_back(dout);
        end
        prev_stall = dout_valid && !rd_ready;
        prev_dout = dout;
      end
      exp_done = nd;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int base, d0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    step();

    // Single pass, la=3
    do_start(1, 3);
    chk("t1_busy", busy, 1);
    wv = '{1024, 512, 512, 512, 512, 512, 512, 512};
    do_write(0);
    wv[0] = -1024;
    do_write(1);
    wv[0] = 65535;
    do_write(2);
    wv[0] = -70000;
    base = got_q.size();
    d0 = done_cnt;
    do_write(3);
    drain(4'b1111, 40);
    chk("t1_count", got_q.size() - base, 4);
    chk("t1_w0", got_q[base], 64'h0201010101010101);
    chk("t1_w1", got_q[base+1], 64'hFE01010101010101);
    chk("t1_w2", got_q[base+2], 64'h7F01010101010101);
    chk("t1_w3", got_q[base+3], 64'h8001010101010101);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_idle", busy, 0);

    // Three passes, la=0, with drain latency
    do_start(3, 0);
    wv = '{0, 0, 300, 0, 0, 0, 0, 0};
    base = got_q.size();
    do_write(0);
    do_write(0);
    chk("t2_nodrain", dout_valid, 0);
    do_write(0);
    chk("t2_lat0", dout_valid, 0);
    step();
    chk("t2_lat1", dout_valid, 0);
    step();
    chk("t2_lat2", dout_valid, 1);
    drain(4'b1111, 20);
    chk("t2_w0", got_q[base], 64'h0000010000000000);

    // Backpressure, la=7, rd_ready 1,0,0,1
    do_start(1, 7);
    wv = '{0, 0, 0, 0, 0, 0, 0, 0};
    base = got_q.size();
    for (int a = 0; a < 8; a++) begin
      wv[0] = a * 512;
      wv[1] = -a * 512;
      do_write(a);
    end
    drain(4'b1001, 100);
    chk("t3_count", got_q.size() - base, 8);
    chk("t3_w0", got_q[base], 64'h0000000000000000);
    chk("t3_w5", got_q[base+5], 64'h05FB000000000000);
    chk("t3_w7", got_q[base+7], 64'h07F9000000000000);

    // Saturation on lane 8
    do_start(2, 0);
    wv = '{0, 0, 0, 0, 0, 0, 0, 2097151};
    base = got_q.size();
    do_write(0);
    chk("t4_ovf_p1", ovf, m_ovf);
    do_write(0);
    chk("t4_ovf_p2", ovf, 1);
    drain(4'b1111, 20);
    chk("t4_w0", got_q[base], 64'h000000000000007F);
    chk("t4_sticky", ovf, 1);
    do_start(1, 0);
    chk("t4_ovf_clr", ovf, 0);
    wv = '{0, 0, 0, 0, 0, 0, 0, 0};
    do_write(0);
    drain(4'b1111, 20);

    // Abort mid-drain, then num_pass=0 acts as one pass
    do_start(1, 3);
    for (int a = 0; a < 4; a++) begin
      wv[0] = (a + 1) * 512;
      do_write(a);
    end
    base = got_q.size();
    d0 = done_cnt;
    for (int n = 0; n < 60 && got_q.size() - base < 2; n++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t5_valid", dout_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_ovf", ovf, 0);
    repeat (4) step();
    chk("t5_nodone", done_cnt - d0, 0);
    chk("t5_count", got_q.size() - base, 2);
    do_start(0, 1);
    wv = '{1024, 0, 0, 0, 0, 0, 0, 0};
    base = got_q.size();
    d0 = done_cnt;
    do_write(0);
    wv[0] = -512;
    do_write(1);
    drain(4'b1111, 30);
    chk("t5_np0_count", got_q.size() - base, 2);
    chk("t5_np0_w0", got_q[base], 64'h0200000000000000);
    chk("t5_np0_w1", got_q[base+1], 64'hFF00000000000000);
    chk("t5_np0_done", done_cnt - d0, 1);

    // Ignored writes: above last_addr in ACC, and during DRAIN
    do_start(1, 2);
    wv = '{0, 1000000, 0, 0, 0, 0, 0, 0};
    do_write(3);
    step();
    chk("t6_busy", busy, 1);
    chk("t6_nodrain", dout_valid, 0);
    base = got_q.size();
    for (int a = 0; a < 3; a++) begin
      wv[1] = 512 * (a + 1);
      do_write(a);
    end
    rd_ready = 1'b0;
    wv[1] = -2000000;
    do_write(2);
    do_write(1);
    chk("t6_draining", busy, 1);
    drain(4'b1111, 30);
    chk("t6_count", got_q.size() - base, 3);
    chk("t6_w0", got_q[base], 64'h0001000000000000);
    chk("t6_w1", got_q[base+1], 64'h0002000000000000);
    chk("t6_w2", got_q[base+2], 64'h0003000000000000);
    chk("t6_ovf", ovf, 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
